// File: rtl/mips32_mem_pkg.sv
// Shared types and constants for the MIPS32 memory responder slice.
package mips32_mem_pkg;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

endpackage

// File: rtl/mips32_sram_1024x32.sv
// Single-port 1024x32 storage: synchronous read and write, one access per cycle.
module mips32_sram_1024x32
    import mips32_mem_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    // No reset: contents must survive rst_n.
    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mips32_mem_responder.sv
// Two-port (instruction/data) memory responder with fair arbitration and
// programmable wait states in front of a synchronous single-port SRAM.
module mips32_mem_responder
    import mips32_mem_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned DEPTH       = mips32_mem_pkg::DEPTH
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        busy
);

    localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    grant_t              last_q, last_d;
    grant_t              port_q, port_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic                pend_q, pend_d;
    logic                i_ok, d_ok;
    grant_t              pick;
    logic                sram_en, sram_we;
    logic [31:0]         sram_rdata;

    // The SRAM result lands one cycle after ACCESS; the owning port stays
    // masked through that cycle and its ack cycle so it cannot re-issue.
    assign i_ok = i_req && !(pend_q && port_q == GRANT_I) && !i_ack;
    assign d_ok = d_req && !(pend_q && port_q == GRANT_D) && !d_ack;
    assign pick = (d_ok && (!i_ok || last_q == GRANT_I)) ? GRANT_D : GRANT_I;
    assign busy = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        port_d  = port_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        err_d   = err_q;
        pend_d  = 1'b0;
        sram_en = 1'b0;
        sram_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_ok || d_ok) begin
                    port_d = pick;
                    last_d = pick;
                    if (pick == GRANT_D) begin
                        addr_d  = d_addr[ADDR_W-1:0];
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        err_d   = (d_addr >= DEPTH);
                    end else begin
                        addr_d  = i_addr[ADDR_W-1:0];
                        we_d    = 1'b0;
                        wdata_d = '0;
                        err_d   = (i_addr >= DEPTH);
                    end
                    if (WAIT_STATES == 0) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACCESS: begin
                sram_en = !err_q;
                sram_we = we_q && !err_q;
                pend_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= GRANT_I;
            port_q  <= GRANT_I;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            i_ack   <= 1'b0;
            i_rdata <= '0;
            i_err   <= 1'b0;
            d_ack   <= 1'b0;
            d_rdata <= '0;
            d_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            i_ack   <= pend_q && port_q == GRANT_I;
            i_err   <= pend_q && port_q == GRANT_I && err_q;
            i_rdata <= (pend_q && port_q == GRANT_I && !err_q) ? sram_rdata : '0;
            d_ack   <= pend_q && port_q == GRANT_D;
            d_err   <= pend_q && port_q == GRANT_D && err_q;
            d_rdata <= (pend_q && port_q == GRANT_D && !err_q && !we_q) ? sram_rdata : '0;
        end
    end

    mips32_sram_1024x32 u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Self-checking bench for mips32_mem_responder (WAIT_STATES=1 and =0 instances).
module tb_mips32_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_ack, i_err, d_ack, d_err, busy;
    logic [31:0] i_rdata, d_rdata;

    logic        w_i_req = 1'b0, w_d_req = 1'b0, w_d_we = 1'b0;
    logic [31:0] w_i_addr = '0, w_d_addr = '0, w_d_wdata = '0;
    logic        w_i_ack, w_i_err, w_d_ack, w_d_err, w_busy;
    logic [31:0] w_i_rdata, w_d_rdata;

    int checks = 0;
    int failures = 0;
    int overlap = 0;
    int leak = 0;

    logic [31:0] model [0:1023];

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    mips32_mem_responder #(.WAIT_STATES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err), .busy(busy)
    );

    mips32_mem_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n),
        .i_req(w_i_req), .i_addr(w_i_addr), .i_ack(w_i_ack), .i_rdata(w_i_rdata), .i_err(w_i_err),
        .d_req(w_d_req), .d_we(w_d_we), .d_addr(w_d_addr), .d_wdata(w_d_wdata),
        .d_ack(w_d_ack), .d_rdata(w_d_rdata), .d_err(w_d_err), .busy(w_busy)
    );

    always @(negedge clk) begin
        if (i_ack && d_ack) overlap++;
        if (w_i_ack && w_d_ack) overlap++;
        if ((!i_ack && i_rdata !== '0) || (!d_ack && d_rdata !== '0)) leak++;
        if ((!w_i_ack && w_i_rdata !== '0) || (!w_d_ack && w_d_rdata !== '0)) leak++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Issues one request on an idle DUT; lat counts posedges after the acceptance edge.
    task automatic txn(input bit ws0, input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output bit err,
                       output int lat);
        logic ack;
        if (ws0) begin
            if (is_d) begin w_d_req = 1'b1; w_d_we = we; w_d_addr = addr; w_d_wdata = wdata; end
            else begin w_i_req = 1'b1; w_i_addr = addr; end
        end else begin
            if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
            else begin i_req = 1'b1; i_addr = addr; end
        end
        lat = -1; rdata = '0; err = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            ack = ws0 ? (is_d ? w_d_ack : w_i_ack) : (is_d ? d_ack : i_ack);
            if (ack) begin
                lat   = n;
                rdata = ws0 ? (is_d ? w_d_rdata : w_i_rdata) : (is_d ? d_rdata : i_rdata);
                err   = ws0 ? (is_d ? w_d_err : w_i_err) : (is_d ? d_err : i_err);
                break;
            end
        end
        i_req = 1'b0; d_req = 1'b0; w_i_req = 1'b0; w_d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Reference: in-range stores update the array, loads read it, out-of-range flags err.
    task automatic ref_txn(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input string tag);
        logic [31:0] r;
        bit          e;
        int          lat;
        bit          oor;
        logic [31:0] exp_r;
        oor   = (addr >= 32'd1024);
        exp_r = (oor || (is_d && we)) ? 32'h0 : model[addr[9:0]];
        txn(1'b0, is_d, is_d && we, addr, wdata, r, e, lat);
        check({tag, "_rdata"}, r, exp_r);
        check({tag, "_err"}, 32'(e), 32'(oor));
        check({tag, "_lat"}, lat, 3);
        if (is_d && we && !oor) model[addr[9:0]] = wdata;
    endtask

    initial begin
        logic [31:0] r;
        bit          e;
        int          lat;
        int          order [$];
        int          acks;

        vecs[0]  = '{1'b1, 32'd5,         32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'd5,         32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'd0,         32'h0000A5A5, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h400,       32'h1,        32'h0,        1'b1};
        vecs[4]  = '{1'b0, 32'd0,         32'h0,        32'h0000A5A5, 1'b0};
        vecs[5]  = '{1'b0, 32'h400,       32'h0,        32'h0,        1'b1};
        vecs[6]  = '{1'b1, 32'd1023,      32'h12345678, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 32'd1023,      32'h0,        32'h12345678, 1'b0};
        vecs[8]  = '{1'b0, 32'hFFFFFFFF,  32'h0,        32'h0,        1'b1};
        vecs[9]  = '{1'b1, 32'd7,         32'h77777777, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 32'd7,         32'h0,        32'h77777777, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_i_ack", 32'(i_ack), 0);
        check("rst_d_ack", 32'(d_ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_errs", {30'd0, i_err, d_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[k]) begin
            txn(1'b0, 1'b1, vecs[k].we, vecs[k].addr, vecs[k].wdata, r, e, lat);
            check($sformatf("vec%0d_rdata", k), r, vecs[k].exp_rdata);
            check($sformatf("vec%0d_err", k), 32'(e), 32'(vecs[k].exp_err));
            check($sformatf("vec%0d_lat", k), lat, 3);
            if (vecs[k].we && !vecs[k].exp_err) model[vecs[k].addr[9:0]] = vecs[k].wdata;
        end

        // Reset in WAIT of a store to 7: no ack, storage untouched, busy drops at once.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd7; d_wdata = 32'hBAD00007;
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy_after", 32'(busy), 0);
        d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_ack) acks++;
        end
        check("abort_no_ack", acks, 0);
        ref_txn(1'b1, 1'b0, 32'd7, 32'h0, "abort_mem7");

        // Contention at reset exit: D first, then I.
        rst_n = 1'b0;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'd2;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd3;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 30 && (i_req || d_req); n++) begin
            @(negedge clk);
            if (d_ack && d_req) begin order.push_back(1); d_req = 1'b0; end
            if (i_ack && i_req) begin order.push_back(0); i_req = 1'b0; end
        end
        i_req = 1'b0; d_req = 1'b0;
        check("contend_count", order.size(), 2);
        check("contend_first_D", order.size() > 0 ? order[0] : 9, 1);
        check("contend_second_I", order.size() > 1 ? order[1] : 9, 0);
        repeat (3) @(negedge clk);

        // Both ports held requesting: grants alternate D, I, D, I.
        order.delete();
        i_req = 1'b1; i_addr = 32'd5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd0;
        for (int n = 0; n < 60 && order.size() < 4; n++) begin
            @(negedge clk);
            if (d_ack) order.push_back(1);
            if (i_ack) order.push_back(0);
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (8) @(negedge clk);
        check("alt_count", order.size(), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("alt_grant%0d", k), order.size() > k ? order[k] : 9, (k % 2 == 0) ? 1 : 0);

        // Randomised traffic against the array model over a small address window.
        for (int a = 0; a < 16; a++) ref_txn(1'b1, 1'b1, 32'(a), $urandom, "fill");
        for (int k = 0; k < 40; k++) begin
            bit          is_d;
            bit          we;
            logic [31:0] addr;
            is_d = 1'($urandom_range(0, 1));
            we   = is_d && ($urandom_range(0, 2) == 0);
            addr = ($urandom_range(0, 4) == 0) ? ($urandom | 32'h400) : 32'($urandom_range(0, 15));
            ref_txn(is_d, we, addr, $urandom, $sformatf("rnd%0d", k));
        end

        // WAIT_STATES=0 instance: ack two cycles after acceptance.
        txn(1'b1, 1'b1, 1'b1, 32'd1, 32'hC0DE0001, r, e, lat);
        check("ws0_store_lat", lat, 2);
        txn(1'b1, 1'b0, 1'b0, 32'd1, 32'h0, r, e, lat);
        check("ws0_fetch_lat", lat, 2);
        check("ws0_fetch_rdata", r, 32'hC0DE0001);
        check("ws0_fetch_err", 32'(e), 0);

        check("ack_overlap", overlap, 0);
        check("rdata_without_ack", leak, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips32_mem_responder.md
MIPS32_MEM_RESPONDER -- requirements
Module: mips32_mem_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter WAIT_STATES, default 1, range 0-7: extra cycles between request acceptance and the memory access.
REQ-003 Parameter DEPTH, default 1024: number of 32-bit words in storage.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 i_req  in  1  instruction-fetch request, held high until i_ack.
REQ-007 i_addr  in  32  instruction word address.
REQ-008 i_ack  out  1  one-cycle completion pulse for the I-port.
REQ-009 i_rdata  out  32  fetched word, valid while i_ack=1.
REQ-010 i_err  out  1  out-of-range flag, valid while i_ack=1.
REQ-011 d_req  in  1  data request, held high until d_ack.
REQ-012 d_we  in  1  1=store, 0=load; sampled at acceptance.
REQ-013 d_addr  in  32  data word address.
REQ-014 d_wdata  in  32  store data; sampled at acceptance.
REQ-015 d_ack  out  1  one-cycle completion pulse for the D-port.
REQ-016 d_rdata  out  32  load data, valid while d_ack=1.
REQ-017 d_err  out  1  out-of-range flag, valid while d_ack=1.
REQ-018 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, WAIT, ACCESS.
REQ-020 IDLE SHALL go to WAIT when a request is accepted and WAIT_STATES>0.
REQ-021 IDLE SHALL go to ACCESS when a request is accepted and WAIT_STATES=0.
REQ-022 On acceptance, the block SHALL latch the granted port, the address, and (for the D-port) the write data and write-enable.
REQ-023 WAIT SHALL load a down-counter with WAIT_STATES-1 and go to ACCESS when the counter reaches 0.
REQ-024 ACCESS SHALL perform exactly one read or write and return to IDLE.
REQ-025 The granted port's ack SHALL be registered and high for exactly the one cycle after ACCESS.
REQ-026 Latency from the acceptance edge to ack high SHALL be WAIT_STATES+2 cycles.
REQ-027 When both requests are present in IDLE, the D-port SHALL win unless the last grant was the D-port, in which case the I-port SHALL win.
REQ-028 last_grant SHALL reset to I.
REQ-029 In the cycle a port's ack is high, that port's req SHALL be ignored; the other port MAY be accepted in that cycle.
REQ-030 Requests arriving while busy=1 SHALL wait; they SHALL NOT be dropped or merged.
REQ-031 The access address SHALL be addr[9:0].
REQ-032 If addr>=DEPTH, the ack SHALL carry err=1 and rdata=0, and a store SHALL NOT modify storage.
REQ-033 rdata SHALL be 0 whenever the corresponding ack is 0.
REQ-034 A load following a store to the same address SHALL return the stored value; there are no stale reads.

Reset
REQ-035 Reset SHALL force state=IDLE, counter=0, last_grant=I, and all outputs to 0.
REQ-036 Reset asserted mid-transaction SHALL abort it: no ack issued and no write performed unless ACCESS had already completed.
REQ-037 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-038 Package mips32_mem_pkg SHALL hold the FSM state type, the DEPTH/ADDR_W (10) constants, and the grant-port enum.
REQ-039 Storage SHALL be a sub-module, mips32_sram_1024x32: single-port, synchronous read and write, one access per cycle.

Verification
REQ-040 Store then load: D-store 0xDEADBEEF to addr 5, then D-load addr 5 -> d_rdata=0xDEADBEEF, d_err=0, each ack 3 cycles after acceptance (WAIT_STATES=1).
REQ-041 Contention: i_req (addr 2) and d_req (addr 3) rise together at reset exit -> D served first, then I; at no point are both acks high.
REQ-042 Alternation: both ports held requesting for 4 transactions -> grants SHALL alternate D, I, D, I.
REQ-043 Out of range: d_we=1, d_addr=0x400, data 0x1 -> d_err=1; a subsequent load from addr 0 returns its prior value unchanged.
REQ-044 Reset abort: rst_n low during WAIT of a store to addr 7 -> no d_ack, mem[7] unchanged, busy=0 immediately.
REQ-045 WAIT_STATES=0: I-fetch of addr 1 -> i_ack exactly 2 cycles after acceptance, carrying mem[1].
